// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapath:
// sequencer state encoding and the default operand width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// One-bit full-adder cell, time-shared by the serial sequencer.
module fulladder (
  output logic carry,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer around a single fulladder cell.
// Operands shift through the cell LSB-first, one bit per clock, with the
// carry held in carry_q between bits.
// Optional macro SERIAL_SUB_EN adds the sub port (A - B = A + ~B + 1).
module serial_adder_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr, b_sr;
  // Holds the WIDTH-1 bits already produced; the MSB comes straight from
  // the cell on the final cycle, so the completed word is {cell sum, sum_sr}.
  logic [WIDTH-2:0]   sum_sr;
  logic [WIDTH-1:0]   sum_cat;
  logic [CNT_W-1:0]   cnt;
  logic               carry_q, cmsb_q, sub_q;
  logic               sub_in;
  logic               fa_b, fa_sum, fa_carry;
  logic               load, step, last;

`ifdef SERIAL_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  assign load    = (state_q == IDLE) && start;
  assign step    = (state_q == RUN);
  assign last    = step && (cnt == CNT_W'(WIDTH - 1));
  assign fa_b    = b_sr[0] ^ sub_q;
  assign sum_cat = {fa_sum, sum_sr};

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  fulladder u_fa (
    .carry (fa_carry),
    .sum   (fa_sum),
    .a     (a_sr[0]),
    .b     (fa_b),
    .cin   (carry_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: IDLE waits for start, RUN walks the bits, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and completion flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      sub_q   <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      a_sr    <= op_a;
      b_sr    <= op_b;
      sub_q   <= sub_in;
      carry_q <= sub_in;
      cnt     <= '0;
    end else if (step) begin
      sum_sr  <= sum_cat[WIDTH-1:1];
      carry_q <= fa_carry;
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      if (last) begin
        // carry_q here is the carry into the MSB; its xor with the carry
        // out of the MSB is the signed overflow.
        cmsb_q <= carry_q;
        result <= sum_cat;
        cout   <= fa_carry;
        ovf    <= carry_q ^ fa_carry;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8), add-only build by
// default; subtract cases are included when SERIAL_SUB_EN is defined.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
`ifdef SERIAL_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
`ifdef SERIAL_SUB_EN
    .sub    (sub),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic c, output logic v);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (s) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur >= 256);
    end
    r = W'(ur & 255);
    v = (sr > 127) || (sr < -128);
  endtask

  task automatic drive_sub(input logic s);
`ifdef SERIAL_SUB_EN
    sub = s;
`else
    if (s) $display("note: subtract request skipped in add-only build");
`endif
  endtask

  // One operation from IDLE; optionally pulses start with junk operands in
  // cycles 3 and 9 of the operation, which must be ignored.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input bit inject);
    logic [W-1:0] er;
    logic ec, ev;
    int dn, pulses;
    model(a, b, s, er, ec, ev);
    dn = 0;
    pulses = 0;
    @(negedge clk);
    op_a = a; op_b = b; drive_sub(s); start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (dn == 0) dn = n;
      end
      if (n == 10) chk({tag, ".busy_low"}, 32'(busy), 32'd0);
      op_a = W'($urandom);
      op_b = W'($urandom);
      drive_sub(1'b0);
      start = (inject && (n == 3 || n == 9)) ? 1'b1 : 1'b0;
    end
    chk({tag, ".done_cycle"}, 32'(dn), 32'd9);
    chk({tag, ".done_pulses"}, 32'(pulses), 32'd1);
    chk({tag, ".result"}, 32'(result), 32'(er));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(ovf), 32'(ev));
  endtask

  initial begin
    logic [W-1:0] ra, rb, er;
    logic rs, ec, ev;
    int seen, cyc, last_dn, gaps_ok;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset.outputs", {27'd0, busy, done, cout, ovf, 1'b0}, 32'd0);
    chk("reset.result", 32'(result), 32'd0);
    rst_n = 1'b1;

    // Directed additions
    run_op("add_3c_05", 8'h3C, 8'h05, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0);
`ifdef SERIAL_SUB_EN
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0);
`endif

    // Starts during RUN and DONE are ignored
    run_op("ignore_start", 8'h12, 8'h34, 1'b0, 1'b1);

    // Random operations
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_SUB_EN
      rs = 1'($urandom_range(1, 0));
`else
      rs = 1'b0;
`endif
      run_op($sformatf("rand%0d", i), ra, rb, rs, 1'b0);
    end

    // Reset in RUN cycle 4 abandons the operation
    @(negedge clk);
    op_a = 8'h55; op_b = 8'h22; drive_sub(1'b0); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.flags", {28'd0, busy, done, cout, ovf}, 32'd0);
    chk("midrst.result", 32'(result), 32'd0);
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 3) rst_n = 1'b1;
      if (done === 1'b1) seen++;
    end
    chk("midrst.no_done", 32'(seen), 32'd0);
    run_op("post_rst", 8'h10, 8'h20, 1'b0, 1'b0);

    // start held high: back-to-back operations, done every W+2 cycles
    @(negedge clk);
    op_a = 8'hA5; op_b = 8'h3C; drive_sub(1'b0); start = 1'b1;
    model(8'hA5, 8'h3C, 1'b0, er, ec, ev);
    seen = 0; last_dn = -1; gaps_ok = 0;
    for (cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (last_dn >= 0 && (cyc - last_dn) == 10) gaps_ok++;
        last_dn = cyc;
        seen++;
        chk($sformatf("b2b.result%0d", seen), 32'(result), 32'(er));
      end
    end
    start = 1'b0;
    chk("b2b.pulses", 32'(seen), 32'd4);
    chk("b2b.gaps", 32'(gaps_ok), 32'd3);
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
